// File: rtl/fram_i2c_pkg.sv
// Shared types and constants for the FRAM-emulating I2C target.
package fram_i2c_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_DEV_SEL,
        S_DEV_ACK,
        S_WORD_ADDR,
        S_WORD_ACK,
        S_WR_DATA,
        S_WR_ACK,
        S_RD_DATA,
        S_RD_ACK,
        S_IGNORE
    } state_t;

    localparam logic [3:0] DEV_TYPE      = 4'b1010;
    localparam logic [3:0] BYTE_BITS     = 4'd8;
    localparam logic [3:0] LAST_DATA_BIT = 4'd7;

endpackage

// File: rtl/i2c_bus_sync.sv
// Synchronizes raw SCL/SDA and produces single-cycle SCL edge, START and STOP pulses.
module i2c_bus_sync (
    input  logic clk,
    input  logic rst,
    input  logic i_scl,
    input  logic i_sda,
    output logic o_sda,
    output logic o_sclRise,
    output logic o_sclFall,
    output logic o_start,
    output logic o_stop
);

    logic r_sclMeta, r_sclSync, r_sclPrev;
    logic r_sdaMeta, r_sdaSync, r_sdaPrev;

    // An idle bus is pulled high, so everything resets to 1 to avoid spurious edges.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sclMeta <= 1'b1;
            r_sclSync <= 1'b1;
            r_sclPrev <= 1'b1;
            r_sdaMeta <= 1'b1;
            r_sdaSync <= 1'b1;
            r_sdaPrev <= 1'b1;
        end else begin
            r_sclMeta <= i_scl;
            r_sclSync <= r_sclMeta;
            r_sclPrev <= r_sclSync;
            r_sdaMeta <= i_sda;
            r_sdaSync <= r_sdaMeta;
            r_sdaPrev <= r_sdaSync;
        end
    end

    assign o_sda     = r_sdaSync;
    assign o_sclRise = r_sclSync & ~r_sclPrev;
    assign o_sclFall = ~r_sclSync & r_sclPrev;
    assign o_start   = r_sclSync & r_sclPrev & r_sdaPrev & ~r_sdaSync;
    assign o_stop    = r_sclSync & r_sclPrev & ~r_sdaPrev & r_sdaSync;

endmodule

// File: rtl/fram_i2c_slave.sv
// FM24CLxx-style FRAM emulation on an I2C target port, backed by an inferred single-port RAM.
// Optional write-protect input is enabled by defining FRAM_SLAVE_WP_EN.
module fram_i2c_slave
    import fram_i2c_pkg::*;
#(
    parameter int         MEM_BYTES = 2048,
    parameter logic [2:0] DEV_ADDR  = 3'b000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        scl_i,
    input  logic        sda_i,
`ifdef FRAM_SLAVE_WP_EN
    input  logic        wp,
`endif
    output logic        sda_t,
    output logic        bus_active,
    output logic        wr_strobe,
    output logic [10:0] wr_addr,
    output logic [7:0]  wr_data
);

    localparam int         ADDR_W   = $clog2(MEM_BYTES);
    localparam int         PAGE_W   = ADDR_W - 8;
    localparam logic [2:0] SEL_MASK = 3'(3'b111 << PAGE_W);

    logic w_sda, w_sclRise, w_sclFall, w_start, w_stop;

    i2c_bus_sync u_sync (
        .clk       (clk),
        .rst       (rst),
        .i_scl     (scl_i),
        .i_sda     (sda_i),
        .o_sda     (w_sda),
        .o_sclRise (w_sclRise),
        .o_sclFall (w_sclFall),
        .o_start   (w_start),
        .o_stop    (w_stop)
    );

    logic w_wrAllowed;
`ifdef FRAM_SLAVE_WP_EN
    logic r_wpMeta, r_wpSync;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wpMeta <= 1'b0;
            r_wpSync <= 1'b0;
        end else begin
            r_wpMeta <= wp;
            r_wpSync <= r_wpMeta;
        end
    end
    assign w_wrAllowed = ~r_wpSync;
`else
    assign w_wrAllowed = 1'b1;
`endif

    state_t              r_state, w_stateNext;
    logic [3:0]          r_bitCnt, w_bitCntNext;
    logic [7:0]          r_shift, w_shiftNext;
    logic [ADDR_W-1:0]   r_ptr, w_ptrNext;
    logic [2:0]          r_page, w_pageNext;
    logic                r_sdaT, w_sdaTNext;
    logic                r_busActive, w_busActiveNext;
    logic                r_masterAck, w_masterAckNext;
    logic                r_wrStrobe, w_wrStrobeNext;
    logic [10:0]         r_wrAddr, w_wrAddrNext;
    logic [7:0]          r_wrData, w_wrDataNext;
    logic                w_memWe;
    logic [7:0]          w_wrByte;
    logic                w_devMatch;
    logic [7:0]          r_mem [MEM_BYTES];
    logic [7:0]          r_rdData;

    assign w_wrByte   = {r_shift[6:0], w_sda};
    assign w_devMatch = (r_shift[7:4] == DEV_TYPE) &&
                        (((r_shift[3:1] ^ DEV_ADDR) & SEL_MASK) == 3'b000);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_bitCnt    <= '0;
            r_shift     <= '0;
            r_ptr       <= '0;
            r_page      <= '0;
            r_sdaT      <= 1'b1;
            r_busActive <= 1'b0;
            r_masterAck <= 1'b0;
            r_wrStrobe  <= 1'b0;
            r_wrAddr    <= '0;
            r_wrData    <= '0;
        end else begin
            r_state     <= w_stateNext;
            r_bitCnt    <= w_bitCntNext;
            r_shift     <= w_shiftNext;
            r_ptr       <= w_ptrNext;
            r_page      <= w_pageNext;
            r_sdaT      <= w_sdaTNext;
            r_busActive <= w_busActiveNext;
            r_masterAck <= w_masterAckNext;
            r_wrStrobe  <= w_wrStrobeNext;
            r_wrAddr    <= w_wrAddrNext;
            r_wrData    <= w_wrDataNext;
        end
    end

    // Read data follows the pointer every cycle, so the next byte is ready well before the ACK slot ends.
    always_ff @(posedge clk) begin
        if (w_memWe) r_mem[r_ptr] <= w_wrByte;
        r_rdData <= r_mem[r_ptr];
    end

    always_comb begin
        w_stateNext     = r_state;
        w_bitCntNext    = r_bitCnt;
        w_shiftNext     = r_shift;
        w_ptrNext       = r_ptr;
        w_pageNext      = r_page;
        w_sdaTNext      = r_sdaT;
        w_busActiveNext = r_busActive;
        w_masterAckNext = r_masterAck;
        w_wrStrobeNext  = 1'b0;
        w_wrAddrNext    = r_wrAddr;
        w_wrDataNext    = r_wrData;
        w_memWe         = 1'b0;

        if (w_start) begin
            w_stateNext     = S_DEV_SEL;
            w_bitCntNext    = '0;
            w_sdaTNext      = 1'b1;
            w_busActiveNext = 1'b1;
        end else if (w_stop) begin
            w_stateNext     = S_IDLE;
            w_sdaTNext      = 1'b1;
            w_busActiveNext = 1'b0;
        end else begin
            case (r_state)
                S_DEV_SEL, S_WORD_ADDR, S_WR_DATA: begin
                    if (w_sclRise && r_bitCnt < BYTE_BITS) begin
                        w_shiftNext  = w_wrByte;
                        w_bitCntNext = r_bitCnt + 4'd1;
                        if (r_state == S_WR_DATA && r_bitCnt == LAST_DATA_BIT && w_wrAllowed) begin
                            w_memWe        = 1'b1;
                            w_wrStrobeNext = 1'b1;
                            w_wrAddrNext   = 11'(r_ptr);
                            w_wrDataNext   = w_wrByte;
                        end
                    end else if (w_sclFall && r_bitCnt == BYTE_BITS) begin
                        w_bitCntNext = '0;
                        if (r_state == S_DEV_SEL) begin
                            w_stateNext = w_devMatch ? S_DEV_ACK : S_IGNORE;
                            w_sdaTNext  = ~w_devMatch;
                        end else if (r_state == S_WORD_ADDR) begin
                            w_stateNext = S_WORD_ACK;
                            w_sdaTNext  = 1'b0;
                            w_ptrNext   = ADDR_W'({r_page, r_shift});
                        end else begin
                            w_stateNext = S_WR_ACK;
                            w_sdaTNext  = 1'b0;
                        end
                    end
                end
                S_DEV_ACK: begin
                    if (w_sclFall) begin
                        w_bitCntNext = '0;
                        if (r_shift[0]) begin
                            w_stateNext = S_RD_DATA;
                            w_sdaTNext  = r_rdData[7];
                            w_shiftNext = {r_rdData[6:0], 1'b1};
                        end else begin
                            w_stateNext = S_WORD_ADDR;
                            w_sdaTNext  = 1'b1;
                            w_pageNext  = r_shift[3:1];
                        end
                    end
                end
                S_WORD_ACK, S_WR_ACK: begin
                    if (w_sclFall) begin
                        w_stateNext  = S_WR_DATA;
                        w_sdaTNext   = 1'b1;
                        w_bitCntNext = '0;
                        if (r_state == S_WR_ACK) w_ptrNext = r_ptr + 1'b1;
                    end
                end
                S_RD_DATA: begin
                    if (w_sclRise && r_bitCnt < BYTE_BITS) begin
                        w_bitCntNext = r_bitCnt + 4'd1;
                    end else if (w_sclFall && r_bitCnt == BYTE_BITS) begin
                        w_stateNext = S_RD_ACK;
                        w_sdaTNext  = 1'b1;
                    end else if (w_sclFall) begin
                        w_sdaTNext  = r_shift[7];
                        w_shiftNext = {r_shift[6:0], 1'b1};
                    end
                end
                S_RD_ACK: begin
                    if (w_sclRise) begin
                        w_masterAckNext = ~w_sda;
                        if (!w_sda) w_ptrNext = r_ptr + 1'b1;
                    end else if (w_sclFall) begin
                        w_bitCntNext = '0;
                        if (r_masterAck) begin
                            w_stateNext = S_RD_DATA;
                            w_sdaTNext  = r_rdData[7];
                            w_shiftNext = {r_rdData[6:0], 1'b1};
                        end else begin
                            w_stateNext = S_IGNORE;
                            w_sdaTNext  = 1'b1;
                        end
                    end
                end
                S_IGNORE: begin
                    w_sdaTNext = 1'b1;
                end
                S_IDLE: begin
                    w_sdaTNext = 1'b1;
                end
                default: begin
                    w_stateNext = S_IDLE;
                    w_sdaTNext  = 1'b1;
                end
            endcase
        end
    end

    assign sda_t      = r_sdaT;
    assign bus_active = r_busActive;
    assign wr_strobe  = r_wrStrobe;
    assign wr_addr    = r_wrAddr;
    assign wr_data    = r_wrData;

endmodule

// File: tb/tb_fram_i2c_slave.sv
// Directed plus randomized I2C transactions against a byte-array/pointer model of the FRAM.
module tb_fram_i2c_slave;

    localparam int MEM = 2048;
    localparam int Q   = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic mScl = 1'b1;
    logic mSda = 1'b1;
    logic sdaLine;
    logic sda_t, bus_active, wr_strobe;
    logic [10:0] wr_addr;
    logic [7:0]  wr_data;
`ifdef FRAM_SLAVE_WP_EN
    logic wp = 1'b0;
`endif

    int errors = 0;
    int checks = 0;

    logic [7:0]  model [MEM];
    int          modelPtr = 0;
    logic [7:0]  txData [$];
    logic [10:0] strobeAddr [$];
    logic [7:0]  strobeData [$];
    int          sdaLowCount = 0;

    assign sdaLine = mSda & sda_t;

    always #5 clk = ~clk;

    fram_i2c_slave #(.MEM_BYTES(MEM), .DEV_ADDR(3'b000)) dut (
        .clk        (clk),
        .rst        (rst),
        .scl_i      (mScl),
        .sda_i      (sdaLine),
`ifdef FRAM_SLAVE_WP_EN
        .wp         (wp),
`endif
        .sda_t      (sda_t),
        .bus_active (bus_active),
        .wr_strobe  (wr_strobe),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data)
    );

    // Record every committed write and every time the target pulls SDA low.
    always @(negedge clk) begin
        if (wr_strobe) begin
            strobeAddr.push_back(wr_addr);
            strobeData.push_back(wr_data);
        end
        if (sda_t === 1'b0) sdaLowCount++;
    end

    initial begin
        #20ms;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic waitQ();
        repeat (Q) @(negedge clk);
    endtask

    // One SCL clock: drive a bit while SCL is low, sample the wired-AND line mid-high.
    task automatic applyStimulus(input logic bitIn, output logic bitOut);
        mSda = bitIn;
        waitQ();
        mScl = 1'b1;
        waitQ();
        bitOut = sdaLine;
        waitQ();
        mScl = 1'b0;
        waitQ();
    endtask

    task automatic i2cStart();
        mSda = 1'b1;
        waitQ();
        mScl = 1'b1;
        waitQ();
        mSda = 1'b0;
        waitQ();
        mScl = 1'b0;
        waitQ();
    endtask

    task automatic i2cStop();
        mSda = 1'b0;
        waitQ();
        mScl = 1'b1;
        waitQ();
        mSda = 1'b1;
        waitQ();
        waitQ();
    endtask

    task automatic sendByte(input logic [7:0] b, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) applyStimulus(b[i], s);
        applyStimulus(1'b1, s);
        ack = ~s;
    endtask

    task automatic recvByte(input logic masterAck, output logic [7:0] b);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            applyStimulus(1'b1, s);
            b[i] = s;
        end
        applyStimulus(~masterAck, s);
    endtask

    // Writes txData starting at addr; commit=0 means the array must stay untouched.
    task automatic doWrite(input logic [10:0] addr, input bit commit);
        int          base;
        logic        ack;
        logic [10:0] expA [$];
        logic [7:0]  expD [$];
        base = strobeAddr.size();
        i2cStart();
        checkOutput("busActive", 32'(bus_active), 32'd1);
        sendByte({4'hA, addr[10:8], 1'b0}, ack);
        checkOutput("wrDevAck", 32'(ack), 32'd1);
        sendByte(addr[7:0], ack);
        checkOutput("wordAddrAck", 32'(ack), 32'd1);
        modelPtr = int'(addr);
        foreach (txData[i]) begin
            sendByte(txData[i], ack);
            checkOutput("dataAck", 32'(ack), 32'd1);
            if (commit) begin
                model[modelPtr] = txData[i];
                expA.push_back(11'(modelPtr));
                expD.push_back(txData[i]);
            end
            modelPtr = (modelPtr + 1) % MEM;
        end
        i2cStop();
        checkOutput("strobeCount", 32'(strobeAddr.size() - base), 32'(expA.size()));
        for (int i = 0; i < expA.size() && base + i < strobeAddr.size(); i++) begin
            checkOutput("strobeAddr", 32'(strobeAddr[base + i]), 32'(expA[i]));
            checkOutput("strobeData", 32'(strobeData[base + i]), 32'(expD[i]));
        end
        checkOutput("busIdle", 32'(bus_active), 32'd0);
    endtask

    // Random read (dummy write then repeated START) or current-address read of n bytes.
    task automatic doRead(input bit randomRd, input logic [10:0] addr, input int n);
        logic       ack;
        logic [7:0] b;
        i2cStart();
        if (randomRd) begin
            sendByte({4'hA, addr[10:8], 1'b0}, ack);
            checkOutput("rdSetDevAck", 32'(ack), 32'd1);
            sendByte(addr[7:0], ack);
            checkOutput("rdSetAddrAck", 32'(ack), 32'd1);
            modelPtr = int'(addr);
            i2cStart();
        end
        sendByte({4'hA, 3'b000, 1'b1}, ack);
        checkOutput("rdDevAck", 32'(ack), 32'd1);
        for (int k = 0; k < n; k++) begin
            recvByte(k != n - 1, b);
            checkOutput("rdData", 32'(b), 32'(model[modelPtr]));
            if (k != n - 1) modelPtr = (modelPtr + 1) % MEM;
        end
        checkOutput("nackRelease", 32'(sda_t), 32'd1);
        i2cStop();
        checkOutput("busIdleRd", 32'(bus_active), 32'd0);
    endtask

    initial begin
        logic        ack;
        logic [10:0] a;
        int          n;
        int          snapLow;
        int          snapStrobe;

        $display("[TB] fram_i2c_slave bench starting");
        repeat (4) @(negedge clk);
        checkOutput("rstSdaT", 32'(sda_t), 32'd1);
        checkOutput("rstBusActive", 32'(bus_active), 32'd0);
        checkOutput("rstWrStrobe", 32'(wr_strobe), 32'd0);
        checkOutput("rstWrAddr", 32'(wr_addr), 32'd0);
        checkOutput("rstWrData", 32'(wr_data), 32'd0);
        rst = 1'b0;
        waitQ();

        // Sequential write of A5 x4 at 0x005, then random read of the same four bytes.
        txData = {8'hA5, 8'hA5, 8'hA5, 8'hA5};
        doWrite(11'h005, 1'b1);
        doRead(1'b1, 11'h005, 4);

        // Wrong device code: never ACKed, never drives SDA, never writes.
        snapLow    = sdaLowCount;
        snapStrobe = strobeAddr.size();
        i2cStart();
        sendByte(8'h90, ack);
        checkOutput("wrongDevNoAck", 32'(ack), 32'd0);
        sendByte(8'hB0, ack);
        checkOutput("ignoreNoAck", 32'(ack), 32'd0);
        checkOutput("ignoreSdaLow", 32'(sdaLowCount - snapLow), 32'd0);
        i2cStop();
        checkOutput("ignoreNoStrobe", 32'(strobeAddr.size() - snapStrobe), 32'd0);

        // Wrap-around write across 0x7FF -> 0x000, then current-address read of 0x001.
        txData = {8'($urandom_range(0, 255))};
        doWrite(11'h001, 1'b1);
        txData = {8'h11, 8'h22};
        doWrite(11'h7FF, 1'b1);
        checkOutput("wrapPtr", 32'(modelPtr), 32'h001);
        doRead(1'b0, 11'h000, 1);

        // Randomized write/read-back bursts, including ones that wrap past the top.
        for (int it = 0; it < 4; it++) begin
            a = 11'($urandom_range(0, MEM - 1));
            n = int'($urandom_range(1, 4));
            txData = {};
            for (int j = 0; j < n; j++) txData.push_back(8'($urandom_range(0, 255)));
            doWrite(a, 1'b1);
            doRead(1'b1, a, n);
        end

        // Reset while the target drives a 0 data bit.
        a = 11'($urandom_range(16, MEM - 1));
        txData = {8'h3C};
        doWrite(a, 1'b1);
        i2cStart();
        sendByte({4'hA, a[10:8], 1'b0}, ack);
        sendByte(a[7:0], ack);
        i2cStart();
        sendByte(8'hA1, ack);
        checkOutput("preRstDevAck", 32'(ack), 32'd1);
        checkOutput("drivingZero", 32'(sda_t), 32'd0);
        rst = 1'b1;
        #1;
        checkOutput("rstAsyncSdaT", 32'(sda_t), 32'd1);
        repeat (3) @(negedge clk);
        mSda = 1'b1;
        waitQ();
        mScl = 1'b1;
        waitQ();
        rst = 1'b0;
        modelPtr = 0;
        waitQ();
        checkOutput("postRstBusActive", 32'(bus_active), 32'd0);
        txData = {8'($urandom_range(0, 255))};
        doWrite(11'h0A0, 1'b1);
        doRead(1'b1, 11'h0A0, 1);

`ifdef FRAM_SLAVE_WP_EN
        // Write-protected write is ACKed but leaves the array alone.
        txData = {8'h5A};
        doWrite(11'h010, 1'b1);
        wp = 1'b1;
        waitQ();
        txData = {8'h3C};
        doWrite(11'h010, 1'b0);
        wp = 1'b0;
        waitQ();
        doRead(1'b1, 11'h010, 1);
`endif

        $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
